ray_box_slab_pipe: RTL

- Pipelined, throughput-1 successor to the single-ray box intersector used in BVH traversal.
- Accepts one ray/box pair per cycle over a valid/ready handshake and applies the slab test in signed fixed point.
- Returns hit, entry distance tnear, exit distance tfar and a pass-through tag.
- Sits between the traversal scheduler (upstream) and the BVH stack/leaf dispatch (downstream).

---
 rtl/ray_box_slab_pipe_if.sv | 32 +++
 rtl/ray_box_slab_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ray_box_slab_pipe_if.sv
// Request/result bundle for ray_box_slab_pipe.
// The master side is the traversal scheduler plus the result consumer.
// The slave side is the slab-test pipeline.
interface ray_box_slab_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [3*WIDTH-1:0]   i_orig;
  logic [3*WIDTH-1:0]   i_inv_dir;
  logic [3*WIDTH-1:0]   i_bbox_min;
  logic [3*WIDTH-1:0]   i_bbox_max;
  logic [WIDTH-1:0]     i_tmax;
  logic [TAG_W-1:0]     i_tag;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_hit;
  logic [WIDTH-1:0]     o_tnear;
  logic [WIDTH-1:0]     o_tfar;
  logic [TAG_W-1:0]     o_tag;

  modport master (
    output i_valid, i_orig, i_inv_dir, i_bbox_min, i_bbox_max, i_tmax, i_tag, i_ready,
    input  o_ready, o_valid, o_hit, o_tnear, o_tfar, o_tag
  );

  modport slave (
    input  i_valid, i_orig, i_inv_dir, i_bbox_min, i_bbox_max, i_tmax, i_tag, i_ready,
    output o_ready, o_valid, o_hit, o_tnear, o_tfar, o_tag
  );
endinterface

// File: rtl/ray_box_slab_pipe.sv
// ray_box_slab_pipe: throughput-1 ray/AABB slab test in signed fixed point.
// Four register stages (S0..S3); a stalled output freezes the whole pipe.
// Optional build macro RIB_SAT_EN: saturate the S1 distance reduction to
// WIDTH bits instead of wrapping.
module ray_box_slab_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter int TAG_W    = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  ray_box_slab_pipe_if.slave bus
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] reduce_t(input logic signed [PW-1:0] v);
`ifdef RIB_SAT_EN
    if (v > PW'(MAXV)) return MAXV;
    if (v < PW'(MINV)) return MINV;
    return v[WIDTH-1:0];
`else
    return WIDTH'(v);
`endif
  endfunction

  logic w_stall, w_en;
  logic r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;

  assign w_stall     = r_vld_p3 & ~bus.i_ready;
  assign w_en        = ~w_stall;
  assign bus.o_ready = ~w_stall;
  assign bus.o_valid = r_vld_p3;

  logic signed [WIDTH-1:0] w_org [3];
  logic signed [WIDTH-1:0] w_inv [3];
  logic signed [WIDTH-1:0] w_min [3];
  logic signed [WIDTH-1:0] w_max [3];

  // Unpack per-axis input coordinates (x lowest).
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_org[a] = bus.i_orig[a*WIDTH +: WIDTH];
      w_inv[a] = bus.i_inv_dir[a*WIDTH +: WIDTH];
      w_min[a] = bus.i_bbox_min[a*WIDTH +: WIDTH];
      w_max[a] = bus.i_bbox_max[a*WIDTH +: WIDTH];
    end
  end

  // ---- S0: slab offsets relative to origin, parallel/inside flags
  logic signed [WIDTH:0]   r_dlo_p0 [3];
  logic signed [WIDTH:0]   r_dhi_p0 [3];
  logic signed [WIDTH-1:0] r_inv_p0 [3];
  logic [2:0]              r_par_p0, r_in_p0;
  logic signed [WIDTH-1:0] r_tmax_p0;
  logic [TAG_W-1:0]        r_tag_p0;

  // ---- S1: full-width products scaled back to the fixed-point format
  logic signed [PW-1:0]    w_plo [3];
  logic signed [PW-1:0]    w_phi [3];
  logic signed [WIDTH-1:0] r_t0_p1 [3];
  logic signed [WIDTH-1:0] r_t1_p1 [3];
  logic [2:0]              r_par_p1, r_in_p1;
  logic signed [WIDTH-1:0] r_tmax_p1;
  logic [TAG_W-1:0]        r_tag_p1;

  // Signed products of the 33-bit offsets and 32-bit reciprocals.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_plo[a] = PW'(r_dlo_p0[a]) * PW'(r_inv_p0[a]);
      w_phi[a] = PW'(r_dhi_p0[a]) * PW'(r_inv_p0[a]);
    end
  end

  // ---- S2: per-axis ordered interval, parallel-axis override
  logic signed [WIDTH-1:0] w_tlo [3];
  logic signed [WIDTH-1:0] w_thi [3];
  logic [2:0]              w_miss;
  logic signed [WIDTH-1:0] r_tlo_p2 [3];
  logic signed [WIDTH-1:0] r_thi_p2 [3];
  logic [2:0]              r_miss_p2;
  logic signed [WIDTH-1:0] r_tmax_p2;
  logic [TAG_W-1:0]        r_tag_p2;

  // Order each slab interval; a parallel ray either spans the axis or misses.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_tlo[a]  = (r_t0_p1[a] < r_t1_p1[a]) ? r_t0_p1[a] : r_t1_p1[a];
      w_thi[a]  = (r_t0_p1[a] < r_t1_p1[a]) ? r_t1_p1[a] : r_t0_p1[a];
      w_miss[a] = r_par_p1[a] & ~r_in_p1[a];
      if (r_par_p1[a] && r_in_p1[a]) begin
        w_tlo[a] = MINV;
        w_thi[a] = MAXV;
      end
    end
  end

  // ---- S3: interval intersection and hit decision
  logic signed [WIDTH-1:0] w_tnear, w_tfar;
  logic                    w_hit;
  logic                    r_hit_p3;
  logic signed [WIDTH-1:0] r_tnear_p3, r_tfar_p3;
  logic [TAG_W-1:0]        r_tag_p3;

  // tnear is clamped at 0 by seeding the max with 0.
  always_comb begin
    w_tnear = '0;
    w_tfar  = MAXV;
    for (int a = 0; a < 3; a++) begin
      if (r_tlo_p2[a] > w_tnear) w_tnear = r_tlo_p2[a];
      if (r_thi_p2[a] < w_tfar)  w_tfar  = r_thi_p2[a];
    end
    w_hit = ~|r_miss_p2 && (w_tnear <= w_tfar) && !w_tfar[WIDTH-1] &&
            (w_tnear <= r_tmax_p2);
  end

  // Valid bits advance together unless the output is stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0 <= bus.i_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // Datapath stages S0..S2 carry no reset; they are qualified by the valid bits.
  always_ff @(posedge i_clk) begin
    if (w_en) begin
      for (int a = 0; a < 3; a++) begin
        r_dlo_p0[a] <= {w_min[a][WIDTH-1], w_min[a]} - {w_org[a][WIDTH-1], w_org[a]};
        r_dhi_p0[a] <= {w_max[a][WIDTH-1], w_max[a]} - {w_org[a][WIDTH-1], w_org[a]};
        r_inv_p0[a] <= w_inv[a];
        r_par_p0[a] <= (w_inv[a] == '0);
        r_in_p0[a]  <= (w_min[a] <= w_org[a]) && (w_org[a] <= w_max[a]);
        r_t0_p1[a]  <= reduce_t(w_plo[a] >>> FRA_BITS);
        r_t1_p1[a]  <= reduce_t(w_phi[a] >>> FRA_BITS);
        r_tlo_p2[a] <= w_tlo[a];
        r_thi_p2[a] <= w_thi[a];
      end
      r_tmax_p0 <= bus.i_tmax;
      r_tag_p0  <= bus.i_tag;
      r_par_p1  <= r_par_p0;
      r_in_p1   <= r_in_p0;
      r_tmax_p1 <= r_tmax_p0;
      r_tag_p1  <= r_tag_p0;
      r_miss_p2 <= w_miss;
      r_tmax_p2 <= r_tmax_p1;
      r_tag_p2  <= r_tag_p1;
    end
  end

  // Output register S3; cleared on reset so the result bus idles at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_p3   <= 1'b0;
      r_tnear_p3 <= '0;
      r_tfar_p3  <= '0;
      r_tag_p3   <= '0;
    end else if (w_en) begin
      r_hit_p3   <= w_hit;
      r_tnear_p3 <= w_tnear;
      r_tfar_p3  <= w_tfar;
      r_tag_p3   <= r_tag_p2;
    end
  end

  assign bus.o_hit   = r_hit_p3;
  assign bus.o_tnear = r_tnear_p3;
  assign bus.o_tfar  = r_tfar_p3;
  assign bus.o_tag   = r_tag_p3;

endmodule
